// File: rtl/fraction_mult_arbiter.sv
// fraction_mult_arbiter
// Shares one fraction_multiplication unit among NREQ requesters. A round-robin
// arbiter picks one pending request, launches the multiplier with a one-cycle
// start pulse, waits for its completion (or aborts after a watchdog timeout)
// and routes the product back to the requester that owned the transaction.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   req                 per-requester request level
//   mplier_bus          requester i multiplier operand in [4i+3:4i]
//   mcand_bus           requester i multiplicand operand in [4i+3:4i]
//   gnt                 one-hot grant pulse (coincides with M_St)
//   rsp_valid           one-hot response pulse to the owning requester
//   rsp_product         product returned with the response
//   rsp_err             qualifies rsp_valid; 1 = aborted by timeout
//   busy                high whenever a transaction is in progress
//   M_St, M_Mplier,
//   M_Mcand             start pulse and operands towards the multiplier
//   M_Product, M_Done   result and completion from the multiplier
module fraction_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   mplier_bus,
  input  logic [4*NREQ-1:0]   mcand_bus,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [6:0]          rsp_product,
  output logic                rsp_err,
  output logic                busy,
  output logic                M_St,
  output logic [3:0]          M_Mplier,
  output logic [3:0]          M_Mcand,
  input  logic [6:0]          M_Product,
  input  logic                M_Done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          r_state, w_stateNxt;
  logic [PW-1:0]   r_ptr, w_ptrNxt;
  logic [PW-1:0]   r_owner, w_ownerNxt;
  logic [7:0]      r_timer, w_timerNxt;
  logic [NREQ-1:0] r_gnt, w_gntNxt;
  logic [NREQ-1:0] r_rspValid, w_rspValidNxt;
  logic [6:0]      r_rspProduct, w_rspProductNxt;
  logic            r_rspErr, w_rspErrNxt;
  logic            r_busy, w_busyNxt;
  logic            r_mSt, w_mStNxt;
  logic [3:0]      r_mplier, w_mplierNxt;
  logic [3:0]      r_mcand, w_mcandNxt;

  logic            w_found;
  logic [PW-1:0]   w_winner;
  int              w_idx;

  // Round-robin search: scan ptr+1, ptr+2, ... modulo NREQ and keep the first
  // requester found, so the last owner has the lowest priority next time.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[PW'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = PW'(w_idx);
      end
    end
  end

  // State and every output are registers; reset clears all outputs at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_ptr        <= PW'(NREQ - 1);
      r_owner      <= '0;
      r_timer      <= '0;
      r_gnt        <= '0;
      r_rspValid   <= '0;
      r_rspProduct <= '0;
      r_rspErr     <= 1'b0;
      r_busy       <= 1'b0;
      r_mSt        <= 1'b0;
      r_mplier     <= '0;
      r_mcand      <= '0;
    end else begin
      r_state      <= w_stateNxt;
      r_ptr        <= w_ptrNxt;
      r_owner      <= w_ownerNxt;
      r_timer      <= w_timerNxt;
      r_gnt        <= w_gntNxt;
      r_rspValid   <= w_rspValidNxt;
      r_rspProduct <= w_rspProductNxt;
      r_rspErr     <= w_rspErrNxt;
      r_busy       <= w_busyNxt;
      r_mSt        <= w_mStNxt;
      r_mplier     <= w_mplierNxt;
      r_mcand      <= w_mcandNxt;
    end
  end

  // Next-state logic. Pulse outputs (gnt, M_St, rsp_valid, rsp_err) default
  // low; operands, product, pointer and owner hold unless updated.
  always_comb begin
    w_stateNxt      = r_state;
    w_ptrNxt        = r_ptr;
    w_ownerNxt      = r_owner;
    w_timerNxt      = r_timer;
    w_gntNxt        = '0;
    w_rspValidNxt   = '0;
    w_rspProductNxt = r_rspProduct;
    w_rspErrNxt     = 1'b0;
    w_mStNxt        = 1'b0;
    w_mplierNxt     = r_mplier;
    w_mcandNxt      = r_mcand;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_mplierNxt = mplier_bus[{w_winner, 2'b00} +: 4];
          w_mcandNxt  = mcand_bus[{w_winner, 2'b00} +: 4];
          w_mStNxt    = 1'b1;
          w_gntNxt    = NREQ'(1) << w_winner;
          w_ptrNxt    = w_winner;
          w_ownerNxt  = w_winner;
          w_stateNxt  = START;
        end
      end
      START: begin
        w_timerNxt = '0;
        w_stateNxt = WAIT;
      end
      WAIT: begin
        // Done has priority over a timeout on the same edge.
        if (M_Done) begin
          w_rspProductNxt = M_Product;
          w_rspValidNxt   = NREQ'(1) << r_owner;
          w_stateNxt      = RESP;
        end else if (r_timer == 8'(TIMEOUT)) begin
          w_rspProductNxt = '0;
          w_rspErrNxt     = 1'b1;
          w_rspValidNxt   = NREQ'(1) << r_owner;
          w_stateNxt      = RESP;
        end else begin
          w_timerNxt = r_timer + 8'd1;
        end
      end
      RESP: begin
        w_stateNxt = IDLE;
      end
      default: begin
        w_stateNxt = IDLE;
      end
    endcase

    w_busyNxt = (w_stateNxt != IDLE);
  end

  assign gnt         = r_gnt;
  assign rsp_valid   = r_rspValid;
  assign rsp_product = r_rspProduct;
  assign rsp_err     = r_rspErr;
  assign busy        = r_busy;
  assign M_St        = r_mSt;
  assign M_Mplier    = r_mplier;
  assign M_Mcand     = r_mcand;

endmodule

// File: doc/fraction_mult_arbiter.md
# fraction_mult_arbiter

Round-robin arbiter and sequencer that shares one `fraction_multiplication` unit among NREQ requesters. It accepts operand pairs from the requesters and starts the multiplier with a one-cycle `St` pulse. It waits for `Done`, then returns `Product` to the owning requester. A watchdog aborts a transaction whose `Done` never arrives. It sits between the client blocks and the single multiplier instance.

## Interface

**Parameters**
- `NREQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 31: number of WAIT cycles without `Done` before abort (1..255).

**Ports**
- `CLK` in 1: clock. All state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `req` in NREQ: per-requester request level.
- `mplier_bus` in 4*NREQ: requester i operand in bits [4i+3:4i].
- `mcand_bus` in 4*NREQ: requester i operand in bits [4i+3:4i].
- `gnt` out NREQ: one-hot grant pulse.
- `rsp_valid` out NREQ: one-hot response pulse.
- `rsp_product` out 7: result for the responding requester.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 means timeout abort.
- `busy` out 1: high in every state except IDLE.
- `M_St` out 1: multiplier start.
- `M_Mplier` out 4: multiplier operand.
- `M_Mcand` out 4: multiplier operand.
- `M_Product` in 7: multiplier result.
- `M_Done` in 1: multiplier completion.

## Operation

**States:** IDLE, START, WAIT, RESP. All outputs are registered.

**Reset (async)**
- State goes to IDLE.
- `gnt`, `rsp_valid`, `rsp_product`, `rsp_err`, `M_St`, `M_Mplier`, `M_Mcand` and `busy` all go to 0.
- Round-robin pointer `ptr` goes to NREQ-1, so requester 0 has first priority.
- Timer goes to 0.

**IDLE**
- If `req` != 0, the winner is the first set bit searching `ptr+1`, `ptr+2`, … modulo NREQ.
- On that edge:
  - `M_Mplier`/`M_Mcand` take the winner's operand slices.
  - `M_St`<=1.
  - `gnt`<=onehot(winner).
  - `ptr`<=winner.
  - Owner register <= winner.
  - State goes to START.
- Otherwise the block stays in IDLE.

**START**
- `gnt` and `M_St` are high for exactly this one cycle.
- Next edge: `gnt`<=0, `M_St`<=0, timer<=0, state goes to WAIT.
- `M_Mplier`/`M_Mcand` hold until the next grant.

**WAIT**
- If `M_Done`=1:
  - `rsp_product`<=`M_Product`.
  - `rsp_err`<=0.
  - `rsp_valid`<=onehot(owner).
  - State goes to RESP.
- Else if timer==TIMEOUT:
  - `rsp_product`<=0.
  - `rsp_err`<=1.
  - `rsp_valid`<=onehot(owner).
  - State goes to RESP.
- Else timer increments.
- If `M_Done` and the timeout coincide, `Done` wins.

**RESP**
- `rsp_valid` is high for one cycle.
- Next edge: `rsp_valid`<=0, `rsp_err`<=0, state goes to IDLE.
- `rsp_product` holds its value until the next response.

**Requester rules**
- Hold `req` and the operands stable until `gnt` is sampled high.
- `req` may drop from the following cycle.
- `req` is ignored outside IDLE; a request pending during a transaction waits.
- `rsp_valid` has no backpressure.

**Arithmetic**
- None. `M_Product` is passed through unchanged, 7 bits.

**Boundary conditions**
- `M_Done` outside WAIT (including in START, or a late `Done` after timeout or reset) is ignored.
- Reset mid-transaction drops it silently: no `rsp_valid`. A multiplier `Done` still in flight is ignored because the block is then in IDLE.
- If `req` deasserts before grant, nothing is granted; no partial capture.

## Timing

- `req` sampled in IDLE at edge E0 → `gnt`/`M_St` high in cycle E0..E1.
- Multiplier samples its operands at E1.
- `M_Done` seen in WAIT at edge Ek → `rsp_valid` high in cycle Ek..Ek+1.
- Back in IDLE at Ek+1; the next grant is possible at edge Ek+2 at the earliest.
- Overhead per transaction: START + RESP + IDLE = 3 cycles plus the multiplier latency.
- Timeout: the error response is registered at the (TIMEOUT+1)th WAIT edge without `Done`.

## Test plan

1. **Reset.** Assert `RST` during START and during WAIT → all outputs are 0 immediately, asynchronously, before any clock edge. After release, the first grant goes to requester 0 when all `req` are set.
2. **Single request.** Drive `req`=4'b0100 with operands 4'h5/4'h3. Model: `Done` 5 cycles after `St`, `Product`=7'h0F. Expect:
   - `gnt`=4'b0100 for one cycle, coincident with `M_St`=1, `M_Mplier`=5 and `M_Mcand`=3.
   - `rsp_valid`=4'b0100, `rsp_product`=7'h0F and `rsp_err`=0, one cycle after `Done`.
3. **Fairness.** Hold `req`=4'b1111 continuously with distinct operands per requester → grants in order 0,1,2,3,0. Each response routes to its owner with that owner's product.
4. **Timeout.** Model never asserts `Done`, TIMEOUT=31 → `rsp_valid`=owner with `rsp_err`=1 and `rsp_product`=0 after 32 WAIT cycles. A `Done` arriving afterwards produces no response.
5. **Simultaneous events.**
   - `Done` on the timeout cycle with `Product`=7'h2A → `rsp_err`=0 and `rsp_product`=7'h2A.
   - New `req` asserted during WAIT → not granted until IDLE.
6. **Reset mid-WAIT.** Assert reset in WAIT, then the model's late `Done` arrives → no `rsp_valid`. A following request on requester 1 is served normally.
